// File: rtl/put_stream_ctrl.sv
// -----------------------------------------------------------------------------
// put_stream_ctrl
//
// Accepts a stream of data words from a core and writes them into one or more
// downstream FIFOs. Accepted words pass through a 2-entry in-order skid buffer,
// so READY is a pure register. READY does not depend combinationally on FULL or
// ENABLE.
//
// Routing modes:
//   mode_q = 0 : broadcast. The head word goes to every channel at once.
//   mode_q = 1 : round-robin. The head word goes to channel rr_ptr only.
//
// A routing-mode change is sampled only while the buffer is empty and idle.
// Words that are already buffered therefore keep the mode they arrived under.
//
// Ports
//   i_clk            rising-edge clock
//   i_rst_n          asynchronous active-low reset
//   i_enable         core presents a valid word on i_data_in
//   i_data_in        data word from the core
//   o_ready          controller accepts a word this cycle (registered)
//   i_mode           0 = broadcast, 1 = round-robin
//   i_full           per-channel FIFO full flags
//   o_fifo_write_en  per-channel one-cycle write strobe (registered)
//   o_fifo_data      shared write data bus (registered)
//   o_wr_count       saturating count of issued words (registered)
// -----------------------------------------------------------------------------
module put_stream_ctrl #(
  parameter int DATA_W = 16,
  parameter int NUM_CH = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_enable,
  input  logic [DATA_W-1:0] i_data_in,
  output logic              o_ready,
  input  logic              i_mode,
  input  logic [NUM_CH-1:0] i_full,
  output logic [NUM_CH-1:0] o_fifo_write_en,
  output logic [DATA_W-1:0] o_fifo_data,
  output logic [15:0]       o_wr_count
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [DATA_W-1:0] r_buf0;      // head entry
  logic [DATA_W-1:0] r_buf1;      // second entry
  logic [1:0]        r_occ;
  logic              r_ready;
  logic              r_mode_q;
  logic [PTR_W-1:0]  r_rr_ptr;
  logic [NUM_CH-1:0] r_wr_en;
  logic [DATA_W-1:0] r_fifo_data;
  logic [15:0]       r_wr_count;

  logic [NUM_CH-1:0] w_target;
  logic              w_issue;
  logic              w_accept;
  logic              w_mode_load;
  logic [DATA_W-1:0] w_buf0_nxt;
  logic [DATA_W-1:0] w_buf1_nxt;
  logic [1:0]        w_occ_nxt;

  // Round-robin targets exactly one channel. Broadcast targets all channels.
  always_comb begin
    w_target = '1;
    if (r_mode_q) w_target = NUM_CH'(1) << r_rr_ptr;
  end

  // Every targeted channel must have room. A full target stalls the issue; the
  // word is never redirected to another channel.
  assign w_issue     = (r_occ != 2'd0) && ((i_full & w_target) == '0);
  assign w_accept    = i_enable && r_ready;
  assign w_mode_load = (r_occ == 2'd0) && !w_accept;

  // Buffer update. The issue is applied first and the accept second. A word
  // accepted in the same cycle as an issue lands in the slot freed by the shift.
  // NOTE: every variable assigned in this block gets a default first, so no latch is inferred.
  always_comb begin
    w_buf0_nxt = r_buf0;
    w_buf1_nxt = r_buf1;
    w_occ_nxt  = r_occ;
    if (w_issue) begin
      w_buf0_nxt = r_buf1;
      w_occ_nxt  = r_occ - 2'd1;
    end
    if (w_accept) begin
      if (w_occ_nxt == 2'd0) w_buf0_nxt = i_data_in;
      else                   w_buf1_nxt = i_data_in;
      w_occ_nxt = w_occ_nxt + 2'd1;
    end
  end

  // NOTE: state uses non-blocking assignments, so every register samples the pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // NOTE: the buffer entries are reset as well. A reset drops buffered words, and nothing
      // stale can reach the FIFO data bus.
      r_buf0      <= '0;
      r_buf1      <= '0;
      r_occ       <= 2'd0;
      r_ready     <= 1'b0;
      r_mode_q    <= 1'b0;
      r_rr_ptr    <= '0;
      r_wr_en     <= '0;
      r_fifo_data <= '0;
      r_wr_count  <= 16'd0;
    end else begin
      r_buf0  <= w_buf0_nxt;
      r_buf1  <= w_buf1_nxt;
      r_occ   <= w_occ_nxt;
      r_ready <= (w_occ_nxt < 2'd2);

      // The mode load and the issue are mutually exclusive: one needs an empty
      // buffer, the other a non-empty one.
      if (w_mode_load) begin
        r_mode_q <= i_mode;
        if (i_mode != r_mode_q) r_rr_ptr <= '0;
      end else if (w_issue && r_mode_q) begin
        if (r_rr_ptr == PTR_W'(NUM_CH - 1)) r_rr_ptr <= '0;
        else                                r_rr_ptr <= r_rr_ptr + PTR_W'(1);
      end

      if (w_issue) begin
        r_wr_en     <= w_target;
        r_fifo_data <= r_buf0;
        if (r_wr_count != 16'hFFFF) r_wr_count <= r_wr_count + 16'd1;
      end else begin
        r_wr_en <= '0;
      end
    end
  end

  assign o_ready         = r_ready;
  assign o_fifo_write_en = r_wr_en;
  assign o_fifo_data     = r_fifo_data;
  assign o_wr_count      = r_wr_count;

endmodule

// File: tb/tb_put_stream_ctrl.sv
// -----------------------------------------------------------------------------
// tb_put_stream_ctrl
//
// Scoreboard bench for put_stream_ctrl with the default parameters
// (DATA_W=16, NUM_CH=2).
//
// The stimulus pushes each hand-computed {write_en, data} pair at the moment it
// offers the word. A monitor pops and compares one entry every time the DUT
// asserts a write strobe. The stimulus drives inputs on the falling edge, and
// the monitor samples outputs on the falling edge.
// -----------------------------------------------------------------------------
module tb_put_stream_ctrl;

  typedef struct {
    logic [1:0]  en;
    logic [15:0] data;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        i_enable;
  logic [15:0] i_data_in;
  logic        o_ready;
  logic        i_mode;
  logic [1:0]  i_full;
  logic [1:0]  o_fifo_write_en;
  logic [15:0] o_fifo_data;
  logic [15:0] o_wr_count;

  put_stream_ctrl #(.DATA_W(16), .NUM_CH(2)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_enable        (i_enable),
    .i_data_in       (i_data_in),
    .o_ready         (o_ready),
    .i_mode          (i_mode),
    .i_full          (i_full),
    .o_fifo_write_en (o_fifo_write_en),
    .o_fifo_data     (o_fifo_data),
    .o_wr_count      (o_wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_writes = 0;
  int   cyc      = 0;
  int   acc_cyc  = 0;
  exp_t exp_q[$];
  int   wcyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: each write strobe must match the next scoreboard entry.
  always @(negedge clk) begin
    if (rst_n && (o_fifo_write_en != 2'b00)) begin
      wcyc.push_back(cyc);
      n_writes++;
      if (exp_q.size() == 0) begin
        check("spurious_write_en", {30'd0, o_fifo_write_en}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("wr_en", {30'd0, o_fifo_write_en}, {30'd0, e.en});
        check("wr_data", {16'd0, o_fifo_data}, {16'd0, e.data});
      end
    end
  end

  // Offer one word and hold it until it is accepted, with a bounded wait.
  task automatic send(input logic [15:0] d, input logic [1:0] en, input bit push = 1'b1);
    int w;
    w = 0;
    @(negedge clk);
    i_enable  = 1'b1;
    i_data_in = d;
    while (!o_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!o_ready) begin
      check("send_ready_timeout", {31'd0, o_ready}, 32'd1);
      i_enable = 1'b0;
    end else begin
      if (push) exp_q.push_back('{en, d});
      @(posedge clk);
      acc_cyc = cyc + 1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      i_enable = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("drain_queue_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nw;
    int a1;
    rst_n     = 1'b0;
    i_enable  = 1'b0;
    i_data_in = 16'd0;
    i_mode    = 1'b0;
    i_full    = 2'b00;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, o_ready}, 32'd0);
    check("rst_wr_en", {30'd0, o_fifo_write_en}, 32'd0);
    check("rst_data", {16'd0, o_fifo_data}, 32'd0);
    check("rst_count", {16'd0, o_wr_count}, 32'd0);
    rst_n = 1'b1;
    #1 check("ready_before_first_edge", {31'd0, o_ready}, 32'd0);
    @(negedge clk);
    check("ready_after_first_edge", {31'd0, o_ready}, 32'd1);

    // Broadcast burst: four back-to-back writes to both channels.
    wcyc.delete();
    send(16'h0001, 2'b11);
    a1 = acc_cyc;
    send(16'h0002, 2'b11);
    send(16'h0003, 2'b11);
    send(16'h0004, 2'b11);
    idle(1);
    wait_drain();
    check("bcast_count", {16'd0, o_wr_count}, 32'd4);
    check("bcast_nwrites", wcyc.size(), 32'd4);
    if (wcyc.size() >= 4) begin
      check("latency_edges_after_accept", wcyc[0] - a1, 32'd1);
      check("burst_back_to_back", wcyc[3] - wcyc[0], 32'd3);
    end

    // Round-robin: the channels alternate, starting from channel 0.
    i_mode = 1'b1;
    idle(2);
    send(16'h0011, 2'b01);
    send(16'h0012, 2'b10);
    send(16'h0013, 2'b01);
    send(16'h0014, 2'b10);
    idle(1);
    wait_drain();
    check("rr_count", {16'd0, o_wr_count}, 32'd8);

    // Broadcast with channel 1 full: READY drops after 2 accepts and no write occurs.
    i_mode = 1'b0;
    idle(2);
    i_full = 2'b10;
    nw = n_writes;
    send(16'h0021, 2'b11);
    send(16'h0022, 2'b11);
    @(negedge clk);
    check("bcast_full_ready_low", {31'd0, o_ready}, 32'd0);
    fork
      send(16'h0023, 2'b11);
      begin
        repeat (3) @(negedge clk);
        check("bcast_full_ready_still_low", {31'd0, o_ready}, 32'd0);
        check("bcast_full_no_writes", n_writes - nw, 32'd0);
        i_full = 2'b00;
      end
    join
    idle(1);
    wait_drain();
    check("bcast_full_count", {16'd0, o_wr_count}, 32'd11);

    // Round-robin: a stall on channel 1 must not skip to channel 0.
    i_mode = 1'b1;
    idle(2);
    send(16'h0031, 2'b01);
    idle(3);
    i_full = 2'b10;
    nw = n_writes;
    send(16'h0032, 2'b10);
    send(16'h0033, 2'b01);
    idle(4);
    check("rr_stall_wr_en", {30'd0, o_fifo_write_en}, 32'd0);
    check("rr_stall_no_skip", n_writes - nw, 32'd0);
    i_full = 2'b00;
    idle(2);
    wait_drain();
    check("rr_stall_count", {16'd0, o_wr_count}, 32'd14);

    // A mode change while 2 words are buffered applies only after the drain.
    i_mode = 1'b0;
    idle(2);
    i_full = 2'b01;
    send(16'h0041, 2'b11);
    send(16'h0042, 2'b11);
    i_mode = 1'b1;
    idle(2);
    i_full = 2'b00;
    idle(4);
    send(16'h0043, 2'b01);
    idle(1);
    wait_drain();
    check("mode_switch_count", {16'd0, o_wr_count}, 32'd17);

    // Reset with a full buffer: every output clears at once and no stale word is written.
    i_full = 2'b11;
    send(16'h0051, 2'b00, 1'b0);
    send(16'h0052, 2'b00, 1'b0);
    idle(1);
    check("pre_reset_ready_low", {31'd0, o_ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_ready", {31'd0, o_ready}, 32'd0);
    check("async_rst_wr_en", {30'd0, o_fifo_write_en}, 32'd0);
    check("async_rst_data", {16'd0, o_fifo_data}, 32'd0);
    check("async_rst_count", {16'd0, o_wr_count}, 32'd0);
    i_full = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    nw = n_writes;
    @(negedge clk);
    check("post_rst_ready", {31'd0, o_ready}, 32'd1);
    idle(4);
    check("no_stale_write", n_writes - nw, 32'd0);

    // Saturation: 65537 round-robin words. The count must stop at 0xFFFF.
    for (int i = 0; i < 65537; i++) begin
      send(16'(i), (i % 2 == 1) ? 2'b10 : 2'b01);
    end
    idle(2);
    wait_drain();
    check("count_saturated", {16'd0, o_wr_count}, 32'h0000FFFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
